// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC result path: accumulator width,
// saturation rails and the {sat, f} entry stored in the result FIFO.
package mac_pkg;

  localparam int unsigned MAC_W = 28;

  localparam logic [MAC_W-1:0] SAT_MAX = 28'h7FFFFFF;
  localparam logic [MAC_W-1:0] SAT_MIN = 28'h8000000;

  typedef struct packed {
    logic                    sat;
    logic signed [MAC_W-1:0] f;
  } mac_result_t;

  localparam int unsigned RESULT_W = $bits(mac_result_t);

  // A result is considered saturated when it sits exactly on either rail.
  function automatic logic is_sat(input logic [MAC_W-1:0] value);
    return (value == SAT_MAX) || (value == SAT_MIN);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; a write into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic             wr_accept_o,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full;
  logic             pop;

  assign full        = (level_q == LW'(DEPTH));
  assign rd_valid_o  = (level_q != '0);
  assign pop         = rd_valid_o && rd_ready_i && !clear_i;
  assign wr_accept_o = wr_en_i && !clear_i && (!full || pop);
  assign level_o     = level_q;

  // Storage is not reset; the head is masked so an empty FIFO reads zero.
  assign rd_data_o = rd_valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (wr_accept_o) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_accept_o) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_accept_o && !pop) begin
        level_d = level_q + LW'(1);
      end else if (!wr_accept_o && pop) begin
        level_d = level_q - LW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/mac_result_sink.sv
// Captures every valid MAC result into a FIFO, tags saturated results and
// keeps saturating result/saturation counters plus a sticky drop flag.
module mac_result_sink
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic signed [MAC_W-1:0]    f,
  input  logic                       clear,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic signed [MAC_W-1:0]    out_data,
  output logic                       out_sat,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           result_cnt,
  output logic [CNT_W-1:0]           sat_cnt,
  output logic                       overflow
);

  mac_result_t          wr_entry;
  mac_result_t          head;
  logic [RESULT_W-1:0]  head_bits;
  logic                 wr_accept;

  logic [CNT_W-1:0]     result_cnt_q, result_cnt_d;
  logic [CNT_W-1:0]     sat_cnt_q, sat_cnt_d;
  logic                 overflow_q, overflow_d;

  assign wr_entry.sat = is_sat(f);
  assign wr_entry.f   = f;

  sync_fifo #(
    .WIDTH (RESULT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .clear_i     (clear),
    .wr_en_i     (valid_in),
    .wr_data_i   (wr_entry),
    .rd_ready_i  (out_ready),
    .wr_accept_o (wr_accept),
    .rd_valid_o  (out_valid),
    .rd_data_o   (head_bits),
    .level_o     (level)
  );

  assign head     = mac_result_t'(head_bits);
  assign out_data = head.f;
  assign out_sat  = head.sat;

  // Clear wins over a same-cycle sample, which is then neither stored nor
  // counted as a drop.
  always_comb begin
    result_cnt_d = result_cnt_q;
    sat_cnt_d    = sat_cnt_q;
    overflow_d   = overflow_q;
    if (clear) begin
      result_cnt_d = '0;
      sat_cnt_d    = '0;
      overflow_d   = 1'b0;
    end else begin
      if (wr_accept && (result_cnt_q != '1)) begin
        result_cnt_d = result_cnt_q + CNT_W'(1);
      end
      if (wr_accept && wr_entry.sat && (sat_cnt_q != '1)) begin
        sat_cnt_d = sat_cnt_q + CNT_W'(1);
      end
      if (valid_in && !wr_accept) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_cnt_q <= '0;
      sat_cnt_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      result_cnt_q <= result_cnt_d;
      sat_cnt_q    <= sat_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign result_cnt = result_cnt_q;
  assign sat_cnt    = sat_cnt_q;
  assign overflow   = overflow_q;

endmodule
